// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces press and release,
// and strobes the hex code of each accepted key. Define KEYPAD_REPEAT_EN for auto-repeat while held.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 4800,
    parameter int unsigned DEBOUNCE_CYCLES = 480000,
    parameter int unsigned REPEAT_CYCLES   = 24000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HELD,
        S_RELEASE
    } state_t;

    localparam logic [31:0] LP_DWELL_LAST  = 32'(SCAN_DIV - 1);
    // The qualifying sample happens one cycle before the stable count starts, hence -2.
    localparam logic [31:0] LP_STABLE_LAST = 32'(DEBOUNCE_CYCLES - 2);

    if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES == 0) begin : g_param_check
        $error("keypad_scanner: need SCAN_DIV >= 4, DEBOUNCE_CYCLES >= 2, REPEAT_CYCLES >= 1");
    end

    logic [3:0]  r_rows_meta;
    logic [3:0]  r_rs;
    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_col;
    logic [1:0]  w_col_next;
    logic [1:0]  r_row;
    logic [1:0]  w_row_next;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_next;
    logic [31:0] w_cnt_inc;
    logic [3:0]  r_cols;
    logic [3:0]  r_key;
    logic [3:0]  w_key_next;
    logic        r_key_valid;
    logic        w_key_valid_next;
    logic        r_key_held;
    logic        w_key_held_next;
    logic        w_row_low;
    logic        w_any_low;
    logic [1:0]  w_low_row;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [31:0] LP_REPEAT_LAST = 32'(REPEAT_CYCLES - 1);

    logic [31:0] r_rep;
    logic [31:0] w_rep_next;
    logic [31:0] w_rep_inc;

    assign w_rep_inc = (r_rep == '1) ? r_rep : r_rep + 32'd1;
`endif

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = 4'h0;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 32'd1;
    assign w_row_low = ~r_rs[r_row];
    assign w_any_low = ~&r_rs;
    assign w_low_row = ~r_rs[0] ? 2'd0 :
                       ~r_rs[1] ? 2'd1 :
                       ~r_rs[2] ? 2'd2 : 2'd3;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next     = r_state;
        w_col_next       = r_col;
        w_row_next       = r_row;
        w_cnt_next       = r_cnt;
        w_key_next       = r_key;
        w_key_valid_next = 1'b0;
        w_key_held_next  = r_key_held;
`ifdef KEYPAD_REPEAT_EN
        w_rep_next       = r_rep;
`endif
        unique case (r_state)
            S_SCAN: begin
                if (r_cnt >= LP_DWELL_LAST) begin
                    w_cnt_next = '0;
                    if (w_any_low) begin
                        w_row_next   = w_low_row;
                        w_state_next = S_DEBOUNCE;
                    end else begin
                        w_col_next = r_col + 2'd1;
                    end
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            S_DEBOUNCE: begin
                if (!w_row_low) begin
                    w_state_next = S_SCAN;
                    w_col_next   = r_col + 2'd1;
                    w_cnt_next   = '0;
                end else if (r_cnt >= LP_STABLE_LAST) begin
                    w_state_next     = S_HELD;
                    w_key_next       = key_code(r_row, r_col);
                    w_key_valid_next = 1'b1;
                    w_key_held_next  = 1'b1;
                    w_cnt_next       = '0;
`ifdef KEYPAD_REPEAT_EN
                    w_rep_next       = '0;
`endif
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            S_HELD: begin
                if (!w_row_low) begin
                    w_state_next = S_RELEASE;
                    w_cnt_next   = '0;
`ifdef KEYPAD_REPEAT_EN
                end else if (r_rep >= LP_REPEAT_LAST) begin
                    w_key_valid_next = 1'b1;
                    w_rep_next       = '0;
                end else begin
                    w_rep_next = w_rep_inc;
`endif
                end
            end
            S_RELEASE: begin
                if (w_row_low) begin
                    // Release bounce: back to HELD without a new strobe.
                    w_state_next = S_HELD;
`ifdef KEYPAD_REPEAT_EN
                    w_rep_next   = '0;
`endif
                end else if (r_cnt >= LP_STABLE_LAST) begin
                    w_state_next    = S_SCAN;
                    w_key_held_next = 1'b0;
                    w_col_next      = r_col + 2'd1;
                    w_cnt_next      = '0;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            default: w_state_next = S_SCAN;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rows_meta <= 4'b1111;
            r_rs        <= 4'b1111;
            r_state     <= S_SCAN;
            r_col       <= 2'd0;
            r_row       <= 2'd0;
            r_cnt       <= '0;
            r_cols      <= 4'b1110;
            r_key       <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep       <= '0;
`endif
        end else begin
            r_rows_meta <= rows;
            r_rs        <= r_rows_meta;
            r_state     <= w_state_next;
            r_col       <= w_col_next;
            r_row       <= w_row_next;
            r_cnt       <= w_cnt_next;
            r_cols      <= ~(4'b0001 << w_col_next);
            r_key       <= w_key_next;
            r_key_valid <= w_key_valid_next;
            r_key_held  <= w_key_held_next;
`ifdef KEYPAD_REPEAT_EN
            r_rep       <= w_rep_next;
`endif
        end
    end

    assign cols      = r_cols;
    assign key       = r_key;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: a keypad model drives rows from cols, and a scoreboard
// holds the expected (code, cycle) of every key_valid strobe.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DB       = 8;
    localparam int REP      = 16;
`ifdef KEYPAD_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    typedef struct {
        logic [3:0] code;
        int         cycle;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed = '0;
    logic        mon_en = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    exp_t        sb[$];

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rows     (rows),
        .cols     (cols),
        .key      (key),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Keypad model: pressed bit r*4+c pulls row r low while column c is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && cols[c] === 1'b0) rows[r] = 1'b0;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            n_checks++;
            if (!(cols === 4'b1110 || cols === 4'b1101 || cols === 4'b1011 || cols === 4'b0111))
                $display("FAIL cols_onehot: cyc=%0d cols=%b, want exactly one low bit", cyc, cols);
            else n_pass++;
            if (key_valid !== 1'b0) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_strobe: cyc=%0d key=%h valid=%b, want no strobe", cyc, key, key_valid);
                end else begin
                    e = sb.pop_front();
                    if (key !== e.code || cyc != e.cycle)
                        $display("FAIL strobe: got key=%h at cyc=%0d, want key=%h at cyc=%0d", key, cyc, e.code, e.cycle);
                    else n_pass++;
                end
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_col(input logic [3:0] want, output int start);
        logic [3:0] prev;
        start = -1;
        prev = cols;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (cols === want && prev !== want) begin
                start = cyc;
                break;
            end
            prev = cols;
        end
        n_checks++;
        if (start < 0) $display("FAIL wait_col_timeout: cols=%b after 64 cycles, want step to %b", cols, want);
        else n_pass++;
    endtask

    // Accept strobe plus, when auto-repeat is built in, one strobe per REP cycles while the
    // row is still seen low (the row is first seen high two cycles after t_rel).
    task automatic push_press(input logic [3:0] code, input int t_acc, input int t_rel);
        exp_t e;
        e.code = code;
        e.cycle = t_acc;
        sb.push_back(e);
        if (REP_ON)
            for (int t = t_acc + REP; t <= t_rel + 2; t += REP) begin
                e.cycle = t;
                sb.push_back(e);
            end
    endtask

    task automatic test_reset();
        int r0;
        logic [3:0] seq [5];
        seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        reset = 1'b1;
        pressed = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({cols, key, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0})
            $display("FAIL reset_values: got cols=%b key=%h valid=%b held=%b, want 1110 0 0 0", cols, key, key_valid, key_held);
        else n_pass++;
        reset = 1'b0;
        mon_en = 1'b1;
        r0 = cyc;
        for (int k = 0; k < 4; k++) begin
            wait_until(r0 + SCAN_DIV*k + SCAN_DIV - 1);
            n_checks++;
            if (cols !== seq[k]) $display("FAIL scan_dwell: cyc=%0d cols=%b, want %b", cyc, cols, seq[k]);
            else n_pass++;
            wait_until(r0 + SCAN_DIV*(k+1));
            n_checks++;
            if (cols !== seq[k+1]) $display("FAIL scan_step: cyc=%0d cols=%b, want %b", cyc, cols, seq[k+1]);
            else n_pass++;
        end
    endtask

    task automatic test_clean_press();
        int p, s, t, x;
        pressed = '0;
        pressed[9] = 1'b1;  // key 8: row 2, column 1
        p = cyc;
        wait_col(4'b1101, s);
        t = s + SCAN_DIV - 1 + DB;
        x = p + 40;
        push_press(4'h8, t, x);
        wait_until(t - 1);
        n_checks++;
        if ({key, key_held} !== {4'h0, 1'b0}) $display("FAIL press_early: key=%h held=%b, want 0 0", key, key_held);
        else n_pass++;
        wait_until(t);
        n_checks++;
        if ({key, key_held, key_valid} !== {4'h8, 1'b1, 1'b1})
            $display("FAIL press_accept: key=%h held=%b valid=%b, want 8 1 1", key, key_held, key_valid);
        else n_pass++;
        wait_until(t + 1);
        n_checks++;
        if ({key_valid, cols} !== {1'b0, 4'b1101}) $display("FAIL press_after: valid=%b cols=%b, want 0 1101", key_valid, cols);
        else n_pass++;
        wait_until(x);
        pressed = '0;
        wait_until(x + 2 + DB - 1);
        n_checks++;
        if (key_held !== 1'b1) $display("FAIL release_early: held=%b, want 1", key_held);
        else n_pass++;
        wait_until(x + 2 + DB);
        n_checks++;
        if ({key_held, cols, key} !== {1'b0, 4'b1011, 4'h8})
            $display("FAIL release: held=%b cols=%b key=%h, want 0 1011 8", key_held, cols, key);
        else n_pass++;
    endtask

    task automatic test_bouncy_press();
        int s;
        wait_col(4'b0111, s);
        wait_until(s + 1);
        pressed[3] = 1'b1;  // row 0 low while column 3 is driven
        wait_until(s + 4);
        pressed[3] = 1'b0;
        n_checks++;
        if (cols !== 4'b0111) $display("FAIL bounce_debounce_entry: cols=%b, want 0111", cols);
        else n_pass++;
        wait_until(s + 6);
        n_checks++;
        if (cols !== 4'b0111) $display("FAIL bounce_frozen: cols=%b, want 0111", cols);
        else n_pass++;
        wait_until(s + 7);
        n_checks++;
        if ({cols, key_held, key} !== {4'b1110, 1'b0, 4'h8})
            $display("FAIL bounce_resume: cols=%b held=%b key=%h, want 1110 0 8", cols, key_held, key);
        else n_pass++;
        wait_until(s + 7 + SCAN_DIV);
        n_checks++;
        if (cols !== 4'b1101) $display("FAIL bounce_dwell: cols=%b, want 1101", cols);
        else n_pass++;
    endtask

    task automatic test_release_bounce();
        int s, t, x;
        exp_t e;
        wait_col(4'b1110, s);
        pressed[5] = 1'b1;  // key 5: row 1, column 1
        wait_col(4'b1101, s);
        t = s + SCAN_DIV - 1 + DB;
        x = s + 30;
        // The bounce restarts the repeat period, so only the accept strobe falls in this hold.
        e.code = 4'h5;
        e.cycle = t;
        sb.push_back(e);
        wait_until(t);
        n_checks++;
        if ({key, key_held} !== {4'h5, 1'b1}) $display("FAIL rb_accept: key=%h held=%b, want 5 1", key, key_held);
        else n_pass++;
        wait_until(t + 3);
        pressed[5] = 1'b0;
        wait_until(t + 6);
        pressed[5] = 1'b1;
        for (int c = t + 5; c <= t + 13; c++) begin
            wait_until(c);
            n_checks++;
            if ({key_held, cols} !== {1'b1, 4'b1101})
                $display("FAIL rb_hold: cyc=%0d held=%b cols=%b, want 1 1101", cyc, key_held, cols);
            else n_pass++;
        end
        wait_until(x);
        pressed[5] = 1'b0;
        wait_until(x + 2 + DB - 1);
        n_checks++;
        if (key_held !== 1'b1) $display("FAIL rb_release_early: held=%b, want 1", key_held);
        else n_pass++;
        wait_until(x + 2 + DB);
        n_checks++;
        if ({key_held, key} !== {1'b0, 4'h5}) $display("FAIL rb_release: held=%b key=%h, want 0 5", key_held, key);
        else n_pass++;
    endtask

    task automatic test_two_keys();
        int s1, t1, y, s2, t2, z;
        pressed[0] = 1'b1;  // key 1: row 0, column 0
        wait_col(4'b1110, s1);
        t1 = s1 + SCAN_DIV - 1 + DB;
        y = s1 + 20;
        s2 = y + 2 + DB + SCAN_DIV;
        t2 = s2 + SCAN_DIV - 1 + DB;
        z = t2 + 5;
        push_press(4'h1, t1, y);
        push_press(4'h9, t2, z);
        wait_until(s1 + 14);
        pressed[10] = 1'b1;  // key 9: row 2, column 2
        wait_until(s1 + 17);
        n_checks++;
        if ({key, key_held, cols} !== {4'h1, 1'b1, 4'b1110})
            $display("FAIL two_first_wins: key=%h held=%b cols=%b, want 1 1 1110", key, key_held, cols);
        else n_pass++;
        wait_until(y);
        pressed[0] = 1'b0;
        wait_until(y + 2 + DB);
        n_checks++;
        if ({key_held, cols, key} !== {1'b0, 4'b1101, 4'h1})
            $display("FAIL two_release1: held=%b cols=%b key=%h, want 0 1101 1", key_held, cols, key);
        else n_pass++;
        wait_until(s2);
        n_checks++;
        if (cols !== 4'b1011) $display("FAIL two_scan_col2: cols=%b, want 1011", cols);
        else n_pass++;
        wait_until(t2 - 1);
        n_checks++;
        if ({key, key_held} !== {4'h1, 1'b0}) $display("FAIL two_before9: key=%h held=%b, want 1 0", key, key_held);
        else n_pass++;
        wait_until(t2);
        n_checks++;
        if ({key, key_held} !== {4'h9, 1'b1}) $display("FAIL two_accept9: key=%h held=%b, want 9 1", key, key_held);
        else n_pass++;
        wait_until(z);
        pressed[10] = 1'b0;
        wait_until(z + 2 + DB);
        n_checks++;
        if (key_held !== 1'b0) $display("FAIL two_release9: held=%b, want 0", key_held);
        else n_pass++;
    endtask

    task automatic test_reset_mid_debounce();
        int s, r0, t, x;
        wait_col(4'b1110, s);
        pressed[3] = 1'b1;  // key A: row 0, column 3
        wait_col(4'b0111, s);
        wait_until(s + 6);
        n_checks++;
        if ({cols, key_held} !== {4'b0111, 1'b0}) $display("FAIL mid_debounce: cols=%b held=%b, want 0111 0", cols, key_held);
        else n_pass++;
        reset = 1'b1;
        wait_until(s + 7);
        n_checks++;
        if ({cols, key, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0})
            $display("FAIL mid_reset_values: cols=%b key=%h valid=%b held=%b, want 1110 0 0 0", cols, key, key_valid, key_held);
        else n_pass++;
        wait_until(s + 8);
        reset = 1'b0;
        r0 = cyc;
        t = r0 + 3*SCAN_DIV + SCAN_DIV - 1 + DB;
        x = r0 + 60;
        push_press(4'hA, t, x);
        wait_until(t - 1);
        n_checks++;
        if ({key, key_held} !== {4'h0, 1'b0}) $display("FAIL redetect_early: key=%h held=%b, want 0 0", key, key_held);
        else n_pass++;
        wait_until(t);
        n_checks++;
        if ({key, key_held} !== {4'hA, 1'b1}) $display("FAIL redetect_accept: key=%h held=%b, want a 1", key, key_held);
        else n_pass++;
        wait_until(x);
        pressed[3] = 1'b0;
        wait_until(x + 2 + DB);
        n_checks++;
        if ({key_held, key} !== {1'b0, 4'hA}) $display("FAIL redetect_release: held=%b key=%h, want 0 a", key_held, key);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bouncy_press();
        test_release_bounce();
        test_two_keys();
        test_reset_mid_debounce();
        repeat (20) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) $display("FAIL missing_strobes: %0d expected strobes never seen, want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
